// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern constants and nibble decoders.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // BCD nibble to segments; A-F are not digits and show blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Sign digit: zero means positive (blank), anything else is a minus.
    function automatic logic [6:0] sign_to_seg(input logic [3:0] nib);
        return (nib == 4'd0) ? SEG_BLANK : SEG_MINUS;
    endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// seg7_lz_mask: combinational leading-zero blank mask for one operand word.
// Ports (all indexed by digit number, element 0 = leftmost digit):
//   i_nib   : nibble of each digit
//   i_sign  : 1 = digit is a sign digit (never LZ-blanked, transparent to the run)
//   o_blank : 1 = digit is a leading zero and should be blanked
module seg7_lz_mask #(
    parameter int NUM_DIGITS = 6
) (
    input  logic [NUM_DIGITS-1:0][3:0] i_nib,
    input  logic [NUM_DIGITS-1:0]      i_sign,
    output logic [NUM_DIGITS-1:0]      o_blank
);

    logic w_run;
    logic w_found;

    always_comb begin
        o_blank = '0;
        w_run   = 1'b1;
        w_found = 1'b0;
        // Zero run from the left; sign digits are skipped, not counted.
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (!i_sign[d]) begin
                o_blank[d] = w_run && (i_nib[d] == 4'd0);
                w_run      = w_run && (i_nib[d] == 4'd0);
            end
        end
        // An all-zero value must still show a single 0 in the last digit.
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (!w_found && !i_sign[d]) begin
                o_blank[d] = 1'b0;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_display_ctrl.sv
// seg7_scan_display_ctrl: multiplexed 7-segment scanner for NUM_SRC operand words.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   src_data       : NUM_SRC words of NUM_DIGITS nibbles, MS nibble = digit 0
//   src_sign_mask  : per source, NUM_DIGITS bits, MSB of each slice = digit 0
//   src_sel        : requested source, latched only at frame boundaries
//   blank_lz       : leading-zero blanking enable (sampled live)
//   blink_mask     : per-digit blink enable, MSB = digit 0
//   seg            : {g,f,e,d,c,b,a}, active high
//   dig_en         : one-hot digit strobe, MSB = digit 0
//   frame_start    : one-cycle pulse when digit 0 is driven
// All per-digit masks and strobes share the data ordering: digit 0 is the
// most significant bit/nibble of its slice. Internally arrays are digit-indexed.
module seg7_scan_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_SRC    = 7,
    parameter int SEL_W      = 3,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC*NUM_DIGITS*4-1:0] src_data,
    input  logic [NUM_SRC*NUM_DIGITS-1:0]   src_sign_mask,
    input  logic [SEL_W-1:0]                src_sel,
    input  logic                            blank_lz,
    input  logic [NUM_DIGITS-1:0]           blink_mask,
    output logic [6:0]                      seg,
    output logic [NUM_DIGITS-1:0]           dig_en,
    output logic                            frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]                 r_pre;
    logic [IW-1:0]                 r_idx;
    logic                          r_run;      // first tick after reset drives index 0
    logic [FW-1:0]                 r_frm;
    logic                          r_phase;
    logic [NUM_DIGITS-1:0][3:0]    r_snap_nib;
    logic [NUM_DIGITS-1:0]         r_snap_sign;
    logic [6:0]                    r_seg;
    logic [NUM_DIGITS-1:0]         r_dig_en;
    logic                          r_fs;

    logic                          w_tick;
    logic [IW-1:0]                 w_idx_nx;
    logic                          w_bound;
    logic                          w_wrap;
    logic                          w_phase_nx;
    int                            w_sel_i;
    logic [NUM_DIGITS-1:0][3:0]    w_live_nib;
    logic [NUM_DIGITS-1:0]         w_live_sign;
    logic [NUM_DIGITS-1:0][3:0]    w_cur_nib;
    logic [NUM_DIGITS-1:0]         w_cur_sign;
    logic [NUM_DIGITS-1:0]         w_lz;
    logic [IW-1:0]                 w_pos;      // bit position of the current digit in MSB-first vectors
    logic [6:0]                    w_seg_nx;
    logic [NUM_DIGITS-1:0]         w_dig_nx;

    assign w_tick   = (r_pre == PW'(SCAN_DIV - 1));
    assign w_idx_nx = (!r_run || r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    assign w_bound  = w_tick && (w_idx_nx == '0);
    assign w_wrap   = w_bound && (r_frm == FW'(BLINK_DIV - 1));
    assign w_phase_nx = r_phase ^ w_wrap;
    assign w_pos    = IW'(NUM_DIGITS - 1) - w_idx_nx;

    // Out-of-range selects fall back to source 0.
    assign w_sel_i = (32'(src_sel) >= NUM_SRC) ? 0 : int'(src_sel);

    always_comb begin
        w_live_nib  = '0;
        w_live_sign = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_live_nib[d]  = src_data[(w_sel_i*NUM_DIGITS + NUM_DIGITS-1-d)*4 +: 4];
            w_live_sign[d] = src_sign_mask[w_sel_i*NUM_DIGITS + NUM_DIGITS-1-d];
        end
    end

    // At the boundary the new snapshot is not yet registered, but digit 0 of the
    // new frame must already come from it, so bypass the live selection.
    assign w_cur_nib  = w_bound ? w_live_nib  : r_snap_nib;
    assign w_cur_sign = w_bound ? w_live_sign : r_snap_sign;

    seg7_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
        .i_nib   (w_cur_nib),
        .i_sign  (w_cur_sign),
        .o_blank (w_lz)
    );

    always_comb begin
        w_dig_nx        = '0;
        w_dig_nx[w_pos] = 1'b1;
        if (w_phase_nx && blink_mask[w_pos])
            w_seg_nx = SEG_BLANK;
        else if (blank_lz && w_lz[w_idx_nx])
            w_seg_nx = SEG_BLANK;
        else if (w_cur_sign[w_idx_nx])
            w_seg_nx = sign_to_seg(w_cur_nib[w_idx_nx]);
        else
            w_seg_nx = bcd_to_seg(w_cur_nib[w_idx_nx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_idx       <= '0;
            r_run       <= 1'b0;
            r_frm       <= '0;
            r_phase     <= 1'b0;
            r_snap_nib  <= '0;
            r_snap_sign <= '0;
            r_seg       <= '0;
            r_dig_en    <= '0;
            r_fs        <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            r_fs  <= 1'b0;
            if (w_tick) begin
                r_idx    <= w_idx_nx;
                r_run    <= 1'b1;
                r_seg    <= w_seg_nx;
                r_dig_en <= w_dig_nx;
                r_fs     <= w_bound;
            end
            if (w_bound) begin
                r_snap_nib  <= w_live_nib;
                r_snap_sign <= w_live_sign;
                r_frm       <= w_wrap ? '0 : r_frm + FW'(1);
                r_phase     <= w_phase_nx;
            end
        end
    end

    assign seg         = r_seg;
    assign dig_en      = r_dig_en;
    assign frame_start = r_fs;

endmodule
